// File: rtl/contador_param.sv
// -----------------------------------------------------------------------------
// contador_param
//
// Parametrised up/down counter: the successor of the plain 8-bit free-running
// up-counter. It adds a configurable width and modulo, a clock-enable
// prescaler, synchronous load and clear, and wrap or saturate behaviour at the
// ends of the range. Status outputs report the terminal count, a one-cycle wrap
// pulse and a sticky overflow flag. Everything runs in a single clock domain.
//
// Parameters
//   WIDTH    : counter width in bits (2..32)
//   MODULO   : count range is 0..MODULO-1 (2..2**WIDTH)
//   PRESCALE : enabled clk cycles per count step (1..65536)
//   SATURATE : 0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset; release is synchronous to clk
//   en       in   count enable; gates both the prescaler and the step
//   up       in   direction, 1 = increment, 0 = decrement
//   load     in   synchronous load strobe (load_val is clamped to MODULO-1)
//   load_val in   value written on load
//   clr      in   synchronous clear; takes priority over load and step
//   q        out  current count, registered
//   tc       out  terminal count, combinational from q and up
//   wrap     out  registered one-cycle pulse on a wrap or a blocked step
//   ovf      out  sticky flag, set by any wrap/saturation event
// -----------------------------------------------------------------------------
module contador_param #(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULO   = 256,
    parameter int              PRESCALE = 1,
    parameter int              SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    // The prescaler needs at least one bit even when PRESCALE is 1.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // The top of the range is held at WIDTH+1 bits so that MODULO = 2**WIDTH
    // compares cleanly against a zero-extended count.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULO - 64'd1);
    localparam logic [WIDTH-1:0] MAX_Q   = MAX_EXT[WIDTH-1:0];
    localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   load_ext;
    logic             at_top;
    logic             at_bot;
    logic [WIDTH-1:0] load_clamped;

    assign cnt_ext      = {1'b0, cnt_q};
    assign load_ext     = {1'b0, load_val};
    assign at_top       = (cnt_ext == MAX_EXT);
    assign at_bot       = (cnt_q == '0);
    assign load_clamped = (load_ext > MAX_EXT) ? MAX_Q : load_val;

    always_comb begin
        cnt_d  = cnt_q;
        pre_d  = pre_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;

        if (clr) begin
            cnt_d = '0;
            pre_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            cnt_d = load_clamped;
            pre_d = '0;
        end else if (en) begin
            if (pre_q == PRE_MAX) begin
                // Prescaler terminal: this enabled cycle is a count step.
                pre_d = '0;
                if (up) begin
                    if (!at_top) begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end else begin
                        if (SATURATE == 0) begin
                            cnt_d = '0;
                        end
                        wrap_d = 1'b1;
                        ovf_d  = 1'b1;
                    end
                end else begin
                    if (!at_bot) begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end else begin
                        if (SATURATE == 0) begin
                            cnt_d = MAX_Q;
                        end
                        wrap_d = 1'b1;
                        ovf_d  = 1'b1;
                    end
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            pre_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign q    = cnt_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;
    assign tc   = up ? at_top : at_bot;

endmodule
